rf_wb_merge: RTL and testbench



---
 rtl/rv32i_pkg.sv | 26 ++
 rtl/rf_wb_fifo.sv | 78 +++++++
 rtl/rf_wb_merge.sv | 171 +++++++++++++++++
 tb/tb_rf_wb_merge.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared types for the integer register-file writeback path.
// Provides the result-write payload struct, the producer source id, and a
// one-hot register decoder used to build the pending-write mask.
package rv32i_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // One pending register-file write: destination register and result data.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wb_req_t;

  // Producer that issued a write; stored in the order FIFO.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

  // One-hot decode of a register index into an XLEN-wide mask.
  function automatic logic [XLEN-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
    return XLEN'(1) << rd;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO used by the writeback merger.
// Registered storage, read/write pointers and occupancy count.  Two push
// lanes are provided so the order FIFO can record two acceptances in one
// cycle (lane a lands first); single-producer instances tie lane b off.
// Every slot is exported together with a per-slot valid bit so the parent
// can scan all queued entries in the same cycle.
module rf_wb_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_a,
  input  logic [WIDTH-1:0]         data_a,
  input  logic                     push_b,
  input  logic [WIDTH-1:0]         data_b,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH-1:0]         slot_valid,
  output logic [DEPTH*WIDTH-1:0]   slot_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_pop;
  logic [AW-1:0]    wr_ptr_b;

  assign do_pop   = pop && (count_reg != '0);
  // Lane b goes behind lane a when both push in the same cycle.
  assign wr_ptr_b = wr_ptr_reg + AW'(push_a);

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(push_a) + AW'(push_b);
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + (AW+1)'(push_a) + (AW+1)'(push_b) - (AW+1)'(do_pop);
    end
  end

  // Payload storage; contents are don't-care until marked valid.
  always_ff @(posedge clk) begin
    if (push_a) begin
      mem_reg[wr_ptr_reg] <= data_a;
    end
    if (push_b) begin
      mem_reg[wr_ptr_b] <= data_b;
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign count = count_reg;

  // A slot is live when its distance from the read pointer is below the count.
  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [AW-1:0] offset;
    assign offset                         = AW'(gi) - rd_ptr_reg;
    assign slot_valid[gi]                 = ({1'b0, offset} < count_reg);
    assign slot_data[gi*WIDTH +: WIDTH]   = mem_reg[gi];
  end

endmodule

// File: rtl/rf_wb_merge.sv
// In-order writeback merger driving the register file's single write port.
// ALU and LSU results are buffered in per-producer FIFOs; an order FIFO of
// source ids replays them one per cycle in global acceptance order.
// busy_mask flags every register with a queued (not yet written) result.
// Optional feature macro: RF_WB_BYPASS_EN -- when nothing is queued, a
// request accepted this cycle is written combinationally instead of queued.
module rf_wb_merge
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_wd,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_wd,
  output logic              lsu_ready,
  output logic [REG_AW-1:0] A3,
  output logic              WE3,
  output logic [XLEN-1:0]   WD3,
  output logic [XLEN-1:0]   busy_mask
);

  localparam int REQ_W = $bits(wb_req_t);
  localparam int ODEPTH = 2 * DEPTH;

  logic               alu_full, alu_empty, lsu_full, lsu_empty;
  logic               order_full, order_empty;
  logic [$clog2(DEPTH):0]  alu_count, lsu_count;
  logic [$clog2(ODEPTH):0] order_count;
  logic [DEPTH-1:0]        alu_slot_valid, lsu_slot_valid;
  logic [DEPTH*REQ_W-1:0]  alu_slot_data, lsu_slot_data;
  logic [ODEPTH-1:0]       order_slot_valid;
  logic [ODEPTH-1:0]       order_slot_data;
  logic               order_head;
  wb_req_t            alu_head, lsu_head;
  wb_req_t            alu_req, lsu_req;
  logic               alu_keep, lsu_keep;
  logic               alu_enq, lsu_enq;
  logic               alu_pop, lsu_pop, order_pop;
  logic [XLEN-1:0]    alu_dec [DEPTH];
  logic [XLEN-1:0]    lsu_dec [DEPTH];
  logic               unused_sink;

  assign alu_ready = !rst && !alu_full;
  assign lsu_ready = !rst && !lsu_full;

  // Writes to x0 complete the handshake but are dropped here.
  assign alu_keep = alu_valid && alu_ready && (alu_rd != '0);
  assign lsu_keep = lsu_valid && lsu_ready && (lsu_rd != '0);

  assign alu_req = '{rd: alu_rd, wd: alu_wd};
  assign lsu_req = '{rd: lsu_rd, wd: lsu_wd};

  // Write-port selection: oldest queued write first, optional bypass when idle.
  always_comb begin
    WE3       = 1'b0;
    A3        = '0;
    WD3       = '0;
    alu_pop   = 1'b0;
    lsu_pop   = 1'b0;
    order_pop = 1'b0;
    alu_enq   = alu_keep;
    lsu_enq   = lsu_keep;
    if (!order_empty) begin
      order_pop = 1'b1;
      WE3       = 1'b1;
      if (wb_src_e'(order_head) == SRC_LSU) begin
        lsu_pop = 1'b1;
        A3      = lsu_head.rd;
        WD3     = lsu_head.wd;
      end else begin
        alu_pop = 1'b1;
        A3      = alu_head.rd;
        WD3     = alu_head.wd;
      end
    end
`ifdef RF_WB_BYPASS_EN
    // Empty order FIFO implies both producer FIFOs are empty too, so a
    // fresh request can go straight to the port without reordering anything.
    else if (alu_keep) begin
      WE3     = 1'b1;
      A3      = alu_rd;
      WD3     = alu_wd;
      alu_enq = 1'b0;
    end else if (lsu_keep) begin
      WE3     = 1'b1;
      A3      = lsu_rd;
      WD3     = lsu_wd;
      lsu_enq = 1'b0;
    end
`endif
  end

  rf_wb_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_alu_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_a     (alu_enq),
    .data_a     (alu_req),
    .push_b     (1'b0),
    .data_b     ({REQ_W{1'b0}}),
    .pop        (alu_pop),
    .head       (alu_head),
    .full       (alu_full),
    .empty      (alu_empty),
    .count      (alu_count),
    .slot_valid (alu_slot_valid),
    .slot_data  (alu_slot_data)
  );

  rf_wb_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_lsu_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_a     (lsu_enq),
    .data_a     (lsu_req),
    .push_b     (1'b0),
    .data_b     ({REQ_W{1'b0}}),
    .pop        (lsu_pop),
    .head       (lsu_head),
    .full       (lsu_full),
    .empty      (lsu_empty),
    .count      (lsu_count),
    .slot_valid (lsu_slot_valid),
    .slot_data  (lsu_slot_data)
  );

  // ALU id on lane a so a simultaneous pair is replayed ALU first.
  rf_wb_fifo #(.WIDTH(1), .DEPTH(ODEPTH)) u_order_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_a     (alu_enq),
    .data_a     (1'(SRC_ALU)),
    .push_b     (lsu_enq),
    .data_b     (1'(SRC_LSU)),
    .pop        (order_pop),
    .head       (order_head),
    .full       (order_full),
    .empty      (order_empty),
    .count      (order_count),
    .slot_valid (order_slot_valid),
    .slot_data  (order_slot_data)
  );

  // Per-slot one-hot decode of queued destinations.
  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_busy
    wb_req_t alu_ent, lsu_ent;
    assign alu_ent     = alu_slot_data[gi*REQ_W +: REQ_W];
    assign lsu_ent     = lsu_slot_data[gi*REQ_W +: REQ_W];
    assign alu_dec[gi] = alu_slot_valid[gi] ? rd_onehot(alu_ent.rd) : '0;
    assign lsu_dec[gi] = lsu_slot_valid[gi] ? rd_onehot(lsu_ent.rd) : '0;
  end

  // Pending-write mask: OR of all queued destinations, x0 never reported.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_mask = busy_mask | alu_dec[i] | lsu_dec[i];
    end
    busy_mask[0] = 1'b0;
  end

  // Status outputs the merger does not need.
  assign unused_sink = ^{alu_count, lsu_count, order_count, order_full,
                         order_slot_valid, order_slot_data, alu_empty, lsu_empty};

endmodule

// File: tb/tb_rf_wb_merge.sv
// Scoreboard bench for rf_wb_merge: stimulus pushes expected writes in
// acceptance order, a negedge monitor pops and compares every port write.
module tb_rf_wb_merge;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wd;
  } sb_t;

`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_wd, lsu_wd;
  logic        alu_ready, lsu_ready;
  logic [4:0]  A3;
  logic        WE3;
  logic [31:0] WD3;
  logic [31:0] busy_mask;

  int   n_cmp = 0;
  int   n_bad = 0;
  sb_t  exp_q [$];
  sb_t  alu_q [$];
  sb_t  lsu_q [$];
  logic [31:0] rf_model [32];
  bit   lsu_stalled;

  rf_wb_merge #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_wd    (alu_wd),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_wd    (lsu_wd),
    .lsu_ready (lsu_ready),
    .A3        (A3),
    .WE3       (WE3),
    .WD3       (WD3),
    .busy_mask (busy_mask)
  );

  always #5 clk = ~clk;

  function automatic sb_t mk(input logic [4:0] rd, input logic [31:0] wd);
    sb_t s;
    s.rd = rd;
    s.wd = wd;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: every write on the port must be the oldest expected write.
  always @(negedge clk) begin
    sb_t e;
    if (!rst && WE3) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got x%0d=%h required no write", A3, WD3);
      end else begin
        e = exp_q.pop_front();
        if (A3 !== e.rd || WD3 !== e.wd) begin
          n_bad++;
          $display("FAIL write_order: got x%0d=%h required x%0d=%h", A3, WD3, e.rd, e.wd);
        end else begin
          $display("write x%0d=%h", A3, WD3);
        end
      end
      rf_model[A3] = WD3;
    end else if (!WE3 && (A3 !== 5'd0 || WD3 !== 32'd0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_port: got A3=%0d WD3=%h required 0/0", A3, WD3);
    end
  end

  // Stream alu_q/lsu_q, each producer holding its request until accepted.
  task automatic run_streams(input int budget);
    int n = 0;
    while ((alu_q.size() > 0 || lsu_q.size() > 0) && n < budget) begin
      @(posedge clk); #1;
      alu_valid = (alu_q.size() > 0);
      lsu_valid = (lsu_q.size() > 0);
      if (alu_valid) begin alu_rd = alu_q[0].rd; alu_wd = alu_q[0].wd; end
      if (lsu_valid) begin lsu_rd = lsu_q[0].rd; lsu_wd = lsu_q[0].wd; end
      if (lsu_valid && !lsu_ready) lsu_stalled = 1'b1;
      if (alu_valid && alu_ready) begin
        if (alu_rd != 5'd0) exp_q.push_back(mk(alu_rd, alu_wd));
        void'(alu_q.pop_front());
      end
      if (lsu_valid && lsu_ready) begin
        if (lsu_rd != 5'd0) exp_q.push_back(mk(lsu_rd, lsu_wd));
        void'(lsu_q.pop_front());
      end
      n++;
    end
    check("stream_budget", 32'(n < budget), 32'd1);
    @(posedge clk); #1;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_wd = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_wd = '0;
    lsu_stalled = 1'b0;

    // Reset state
    #3;
    check("rst_alu_ready", 32'(alu_ready), 32'd0);
    check("rst_lsu_ready", 32'(lsu_ready), 32'd0);
    check("rst_we3", 32'(WE3), 32'd0);
    check("rst_busy", busy_mask, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_alu_ready", 32'(alu_ready), 32'd1);
    check("rel_lsu_ready", 32'(lsu_ready), 32'd1);

    // Single ALU write, latency and busy bit
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
    check("t1_alu_ready", 32'(alu_ready), 32'd1);
    exp_q.push_back(mk(5'd5, 32'hDEADBEEF));
    @(negedge clk);
    check("t1_we3_accept_cycle", 32'(WE3), 32'(BYP));
    check("t1_busy_accept_cycle", busy_mask, 32'd0);
    @(posedge clk); #1;
    alu_valid = 1'b0;
    @(negedge clk);
    check("t1_we3_next", 32'(WE3), 32'(!BYP));
    check("t1_a3_next", 32'(A3), BYP ? 32'd0 : 32'd5);
    check("t1_busy_next", busy_mask, BYP ? 32'd0 : 32'h0000_0020);
    @(negedge clk);
    check("t1_we3_after", 32'(WE3), 32'd0);
    check("t1_busy_after", busy_mask, 32'd0);

    // Same rd from both producers in one cycle: ALU then LSU
    alu_q.push_back(mk(5'd7, 32'h1));
    lsu_q.push_back(mk(5'd7, 32'h2));
    run_streams(20);
    drain("t2_drain");
    check("t2_x7_final", rf_model[7], 32'h2);

    // x0 write is accepted and dropped
    @(posedge clk); #1;
    check("t3_alu_ready", 32'(alu_ready), 32'd1);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_wd = 32'hFFFFFFFF;
    @(negedge clk);
    check("t3_we3", 32'(WE3), 32'd0);
    @(posedge clk); #1;
    alu_valid = 1'b0;
    @(negedge clk);
    check("t3_we3_next", 32'(WE3), 32'd0);
    check("t3_busy", busy_mask, 32'd0);

    // Back-pressure: both producers stream, LSU FIFO fills
    for (int i = 0; i < 4; i++) alu_q.push_back(mk(5'(1 + i), 32'hA000_0000 + 32'(i)));
    for (int i = 0; i < 4; i++) lsu_q.push_back(mk(5'(20 + i), 32'hB000_0000 + 32'(i)));
    lsu_stalled = 1'b0;
    run_streams(40);
    check("t4_lsu_stalled", 32'(lsu_stalled), 32'd1);
    drain("t4_drain");
    check("t4_x23", rf_model[23], 32'hB000_0003);

    // Reset with writes pending flushes them
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_wd = 32'h10;
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_wd = 32'h11;
    exp_q.push_back(mk(5'd10, 32'h10));
    exp_q.push_back(mk(5'd11, 32'h11));
    @(posedge clk); #1;
    alu_rd = 5'd12; alu_wd = 32'h12;
    lsu_rd = 5'd13; lsu_wd = 32'h13;
    exp_q.push_back(mk(5'd12, 32'h12));
    exp_q.push_back(mk(5'd13, 32'h13));
    @(posedge clk); #1;
    alu_valid = 1'b0; lsu_valid = 1'b0;
    check("t5_busy_before_rst", 32'(busy_mask != 32'd0), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("t5_we3", 32'(WE3), 32'd0);
    check("t5_busy", busy_mask, 32'd0);
    check("t5_alu_ready", 32'(alu_ready), 32'd0);
    check("t5_lsu_ready", 32'(lsu_ready), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_no_write_x12", rf_model[12], 32'd0);
    check("t5_busy_after", busy_mask, 32'd0);

    // Idle merger, ALU x3: same cycle with bypass, next cycle without
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'h55;
    exp_q.push_back(mk(5'd3, 32'h55));
    @(negedge clk);
    check("t6_we3_same", 32'(WE3), 32'(BYP));
    check("t6_a3_same", 32'(A3), BYP ? 32'd3 : 32'd0);
    @(posedge clk); #1;
    alu_valid = 1'b0;
    @(negedge clk);
    check("t6_we3_next", 32'(WE3), 32'(!BYP));
    check("t6_a3_next", 32'(A3), BYP ? 32'd0 : 32'd3);
    drain("t6_drain");
    check("t6_x3", rf_model[3], 32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
